// File: rtl/pc_pkg.sv
// Shared types and defaults for the IF-stage PC generator.
// Holds the state enum, default parameters and the alignment-mask helper.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_BOOT,
    PC_RUN,
    PC_HALTED
  } pc_state_e;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam int          INSTR_BYTES_DEF  = 4;

  function automatic int unsigned lsb_mask(input int unsigned ib);
    return ib - 1;
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: trap > redirect > sequential advance > hold.
// Ports: current_pc/en/advance, trap_*, redirect_* in; next_pc, err out.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int INSTR_BYTES = INSTR_BYTES_DEF
) (
  input  logic [XLEN-1:0] current_pc,
  input  logic            en,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            advance,
  output logic [XLEN-1:0] next_pc,
  output logic            err
);

  localparam logic [XLEN-1:0] LSB =
    XLEN'(lsb_mask(INSTR_BYTES));
  localparam logic [XLEN-1:0] INC =
    XLEN'(INSTR_BYTES);

  logic aligned;
  assign aligned = (redirect_pc & LSB) == '0;

  always_comb begin
    next_pc = current_pc;
    err     = 1'b0;
    if (en) begin
      if (trap_valid) begin
        next_pc = trap_pc & ~LSB;
      end else if (redirect_valid) begin
        if (aligned) next_pc = redirect_pc;
        else         err     = 1'b1;
      end else if (advance) begin
        next_pc = current_pc + INC;
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// IF-stage program counter with boot delay, debug halt and redirects.
// Ports: clk, rst_n, stall, redirect_*, trap_*, halt/resume, fetch_*, status.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
  parameter int              INSTR_BYTES  = INSTR_BYTES_DEF,
  parameter int              BOOT_DELAY   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            halt_req,
  input  logic            resume_req,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] fetch_pc,
  output logic [XLEN-1:0] current_pc,
  output logic            halted,
  output logic            misaligned_err
);

  pc_state_e       state;
  logic [3:0]      boot_cnt;
  logic            halt_pending;
  logic [XLEN-1:0] next_pc;
  logic            next_err;
  logic            boot_done;
  logic            advance;

  // Any redirect cancels the request of its cycle.
  assign fetch_valid = (state == PC_RUN) & ~stall
                     & ~trap_valid & ~redirect_valid;
  assign fetch_pc    = current_pc;
  assign halted      = (state == PC_HALTED);
  assign advance     = fetch_valid & fetch_ready;
  assign boot_done   = (BOOT_DELAY == 0) ||
                       (boot_cnt == 4'(BOOT_DELAY - 1));

  pc_next_sel #(
    .XLEN        (XLEN),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_sel (
    .current_pc     (current_pc),
    .en             (state != PC_BOOT),
    .trap_valid     (trap_valid),
    .trap_pc        (trap_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .advance        (advance),
    .next_pc        (next_pc),
    .err            (next_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      current_pc     <= RESET_VECTOR;
      state          <= PC_BOOT;
      boot_cnt       <= '0;
      halt_pending   <= 1'b0;
      misaligned_err <= 1'b0;
    end else begin
      current_pc     <= next_pc;
      misaligned_err <= next_err;
      unique case (state)
        PC_BOOT: begin
          if (boot_done) begin
            state <= (halt_pending | halt_req)
                   ? PC_HALTED : PC_RUN;
            halt_pending <= 1'b0;
            boot_cnt     <= '0;
          end else begin
            boot_cnt <= boot_cnt + 4'd1;
            if (halt_req) halt_pending <= 1'b1;
          end
        end
        PC_RUN: begin
          if (halt_req) state <= PC_HALTED;
        end
        PC_HALTED: begin
          if (resume_req & ~halt_req) state <= PC_RUN;
        end
        default: state <= PC_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed table, hand sequences, random.
// Random phase uses a mode/PC reference model built from the rules.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, redirect_valid, trap_valid;
  logic [31:0] redirect_pc, trap_pc;
  logic        halt_req, resume_req, fetch_ready;
  logic        fetch_valid, halted, misaligned_err;
  logic [31:0] fetch_pc, current_pc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_valid     (trap_valid),
    .trap_pc        (trap_pc),
    .halt_req       (halt_req),
    .resume_req     (resume_req),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .fetch_pc       (fetch_pc),
    .current_pc     (current_pc),
    .halted         (halted),
    .misaligned_err (misaligned_err)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        st, rv;
    logic [31:0] rpc;
    logic        tv;
    logic [31:0] tpc;
    logic        hr, rs, rdy;
    logic        fv;
    logic [31:0] pc;
    logic        hl, er;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic st, logic rv, logic [31:0] rpc,
    logic tv, logic [31:0] tpc,
    logic hr, logic rs, logic rdy,
    logic fv, logic [31:0] pc, logic hl, logic er);
    vec_t v;
    v.st = st; v.rv = rv; v.rpc = rpc;
    v.tv = tv; v.tpc = tpc;
    v.hr = hr; v.rs = rs; v.rdy = rdy;
    v.fv = fv; v.pc = pc; v.hl = hl; v.er = er;
    return v;
  endfunction

  task automatic clr_in();
    stall = 0; redirect_valid = 0; redirect_pc = 0;
    trap_valid = 0; trap_pc = 0;
    halt_req = 0; resume_req = 0; fetch_ready = 0;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // Reference model: modes 0=boot 1=run 2=halted.
  int          m_mode;
  int          m_boot;
  bit          m_hp;
  logic [31:0] m_pc;
  bit          m_err;
  localparam int IB = 4;
  localparam int BD = 2;

  task automatic model_step(output bit fv_exp);
    bit fv;
    fv = (m_mode == 1) && !stall && !trap_valid && !redirect_valid;
    fv_exp = fv;
    m_err = 0;
    if (m_mode != 0) begin
      if (trap_valid)
        m_pc = trap_pc - (trap_pc % IB);
      else if (redirect_valid) begin
        if (redirect_pc % IB == 0) m_pc = redirect_pc;
        else m_err = 1;
      end else if (fv && fetch_ready)
        m_pc = m_pc + IB;
    end
    case (m_mode)
      0: begin
        m_boot++;
        if (halt_req) m_hp = 1;
        if (m_boot >= BD) begin
          m_mode = m_hp ? 2 : 1;
          m_hp = 0;
        end
      end
      1: if (halt_req) m_mode = 2;
      default: if (resume_req && !halt_req) m_mode = 1;
    endcase
  endtask

  initial begin
    logic [31:0] prev;
    bit          fvx;
    rst_n = 0;
    clr_in();
    #12;
    chk("rst_pc", current_pc, 32'h0);
    chk("rst_fv", {31'b0, fetch_valid}, 0);
    chk("rst_halted", {31'b0, halted}, 0);
    chk("rst_err", {31'b0, misaligned_err}, 0);

    //       st rv rpc           tv tpc     hr rs rdy fv pc           hl er
    tbl.push_back(mk(0,0,0,            0,0,     0,0,1, 0,32'h0,       0,0));
    tbl.push_back(mk(0,0,0,            0,0,     0,0,1, 0,32'h0,       0,0));
    tbl.push_back(mk(0,0,0,            0,0,     0,0,1, 1,32'h4,       0,0));
    tbl.push_back(mk(0,0,0,            0,0,     0,0,1, 1,32'h8,       0,0));
    tbl.push_back(mk(0,0,0,            0,0,     0,0,1, 1,32'hC,       0,0));
    tbl.push_back(mk(0,0,0,            0,0,     0,0,1, 1,32'h10,      0,0));
    tbl.push_back(mk(0,0,0,            0,0,     0,0,0, 1,32'h10,      0,0));
    tbl.push_back(mk(0,0,0,            0,0,     0,0,0, 1,32'h10,      0,0));
    tbl.push_back(mk(0,0,0,            0,0,     0,0,0, 1,32'h10,      0,0));
    tbl.push_back(mk(0,0,0,            0,0,     0,0,1, 1,32'h14,      0,0));
    tbl.push_back(mk(1,1,32'h200,      1,32'h103,0,0,1, 0,32'h100,     0,0));
    tbl.push_back(mk(0,0,0,            0,0,     0,0,1, 1,32'h104,     0,0));
    tbl.push_back(mk(0,1,32'h202,      0,0,     0,0,1, 0,32'h104,     0,1));
    tbl.push_back(mk(0,0,0,            0,0,     0,0,0, 1,32'h104,     0,0));
    tbl.push_back(mk(0,1,32'h20,       0,0,     0,0,1, 0,32'h20,      0,0));
    tbl.push_back(mk(0,0,0,            0,0,     1,0,1, 1,32'h24,      1,0));
    tbl.push_back(mk(0,0,0,            0,0,     0,0,1, 0,32'h24,      1,0));
    tbl.push_back(mk(0,1,32'h80,       0,0,     0,0,1, 0,32'h80,      1,0));
    tbl.push_back(mk(0,0,0,            0,0,     1,1,1, 0,32'h80,      1,0));
    tbl.push_back(mk(0,0,0,            0,0,     0,1,1, 0,32'h80,      0,0));
    tbl.push_back(mk(0,0,0,            0,0,     0,0,1, 1,32'h84,      0,0));
    tbl.push_back(mk(1,0,0,            0,0,     0,0,1, 0,32'h84,      0,0));
    tbl.push_back(mk(0,1,32'hFFFF_FFFC,0,0,     0,0,1, 0,32'hFFFF_FFFC,0,0));
    tbl.push_back(mk(0,0,0,            0,0,     0,0,1, 1,32'h0,       0,0));
    tbl.push_back(mk(0,0,0,            1,32'h1FF,0,0,1, 0,32'h1FC,     0,0));

    @(posedge clk);
    #1;
    rst_n = 1;
    prev = 32'h0;
    for (int i = 0; i < tbl.size(); i++) begin
      stall = tbl[i].st;
      redirect_valid = tbl[i].rv;
      redirect_pc = tbl[i].rpc;
      trap_valid = tbl[i].tv;
      trap_pc = tbl[i].tpc;
      halt_req = tbl[i].hr;
      resume_req = tbl[i].rs;
      fetch_ready = tbl[i].rdy;
      #2;
      chk($sformatf("t%0d_fv", i), {31'b0, fetch_valid},
          {31'b0, tbl[i].fv});
      chk($sformatf("t%0d_fpc", i), fetch_pc, prev);
      edge1();
      chk($sformatf("t%0d_pc", i), current_pc, tbl[i].pc);
      chk($sformatf("t%0d_hl", i), {31'b0, halted},
          {31'b0, tbl[i].hl});
      chk($sformatf("t%0d_er", i), {31'b0, misaligned_err},
          {31'b0, tbl[i].er});
      prev = tbl[i].pc;
    end

    // Asynchronous reset during a stall, then halt requested in BOOT.
    clr_in();
    stall = 1;
    fetch_ready = 1;
    #2;
    rst_n = 0;
    #1;
    chk("mid_rst_pc", current_pc, 32'h0);
    chk("mid_rst_fv", {31'b0, fetch_valid}, 0);
    chk("mid_rst_halted", {31'b0, halted}, 0);
    edge1();
    rst_n = 1;
    stall = 0;
    halt_req = 1;
    #2;
    chk("boot0_fv", {31'b0, fetch_valid}, 0);
    edge1();
    halt_req = 0;
    chk("boot1_fv", {31'b0, fetch_valid}, 0);
    chk("boot1_halted", {31'b0, halted}, 0);
    edge1();
    chk("boot_halt", {31'b0, halted}, 1);
    chk("boot_halt_fv", {31'b0, fetch_valid}, 0);
    chk("boot_halt_pc", current_pc, 32'h0);
    resume_req = 1;
    edge1();
    resume_req = 0;
    chk("resume_halted", {31'b0, halted}, 0);
    chk("resume_fv", {31'b0, fetch_valid}, 1);
    chk("resume_fpc", fetch_pc, 32'h0);
    edge1();
    chk("resume_adv", current_pc, 32'h4);

    // Random phase against the model.
    m_mode = 1; m_boot = BD; m_hp = 0;
    m_pc = 32'h4; m_err = 0;
    for (int c = 0; c < 600; c++) begin
      stall = ($urandom_range(0, 4) == 0);
      trap_valid = ($urandom_range(0, 15) == 0);
      trap_pc = $urandom;
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_pc = $urandom_range(0, 1) ? ($urandom & ~32'h3)
                  : $urandom;
      if ($urandom_range(0, 9) == 0)
        redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hC);
      halt_req = ($urandom_range(0, 19) == 0);
      resume_req = ($urandom_range(0, 2) == 0);
      fetch_ready = ($urandom_range(0, 3) != 0);
      #2;
      chk("rnd_fpc", fetch_pc, m_pc);
      model_step(fvx);
      chk("rnd_fv", {31'b0, fetch_valid}, {31'b0, fvx});
      edge1();
      chk("rnd_pc", current_pc, m_pc);
      chk("rnd_hl", {31'b0, halted}, {31'b0, m_mode == 2});
      chk("rnd_er", {31'b0, misaligned_err}, {31'b0, m_err});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
